four_slot_tdm_demux: RTL

- Receive side of the four-input selector channel. A transmitter drives select {s1,s0} through 00,01,10,11 every valid cycle, which time-division multiplexes four sources onto one line.
- This block locks to that slot sequence using a frame-sync marker, collects the four slot samples, and presents them together as parallel registered outputs out0..out3.
- It sits directly after the serial link and hands one complete frame at a time to downstream logic.

---
 rtl/four_slot_tdm_demux_pkg.sv | 15 +
 rtl/four_slot_tdm_demux.sv | 131 +++++++++++++
 2 files changed

// File: rtl/four_slot_tdm_demux_pkg.sv
// Shared encodings for the four-slot TDM receive path: slot indices follow the
// selector's {s1,s0} mapping, plus the alignment state encoding.
package four_slot_tdm_demux_pkg;

    localparam logic [1:0] SLOT0 = 2'b00;
    localparam logic [1:0] SLOT1 = 2'b01;
    localparam logic [1:0] SLOT2 = 2'b10;
    localparam logic [1:0] SLOT3 = 2'b11;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

endpackage

// File: rtl/four_slot_tdm_demux.sv
// Locks to the frame-sync marker, gathers four slot samples into shadow
// registers and publishes them as one complete frame on out0..out3.
module four_slot_tdm_demux
    import four_slot_tdm_demux_pkg::*;
#(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] din,
    input  logic         din_valid,
    input  logic         frame_sync,
    output logic [W-1:0] out0,
    output logic [W-1:0] out1,
    output logic [W-1:0] out2,
    output logic [W-1:0] out3,
    output logic [1:0]   sel,
    output logic         frame_valid,
    output logic         locked,
    output logic         sync_err
);

    state_t       state_q, state_d;
    logic [1:0]   slot_q, slot_d;
    logic [W-1:0] shadow0_q, shadow0_d;
    logic [W-1:0] shadow1_q, shadow1_d;
    logic [W-1:0] shadow2_q, shadow2_d;
    logic [W-1:0] out0_q, out0_d;
    logic [W-1:0] out1_q, out1_d;
    logic [W-1:0] out2_q, out2_d;
    logic [W-1:0] out3_q, out3_d;
    logic         frame_valid_q, frame_valid_d;
    logic         sync_err_q, sync_err_d;

    always_comb begin
        state_d       = state_q;
        slot_d        = slot_q;
        shadow0_d     = shadow0_q;
        shadow1_d     = shadow1_q;
        shadow2_d     = shadow2_q;
        out0_d        = out0_q;
        out1_d        = out1_q;
        out2_d        = out2_q;
        out3_d        = out3_q;
        frame_valid_d = 1'b0;
        sync_err_d    = 1'b0;

        if (din_valid) begin
            case (state_q)
                HUNT: begin
                    if (frame_sync) begin
                        shadow0_d = din;
                        slot_d    = SLOT1;
                        state_d   = LOCKED;
                    end
                end
                LOCKED: begin
                    if (frame_sync) begin
                        // A marker mid-frame restarts the frame at this sample.
                        sync_err_d = (slot_q != SLOT0);
                        shadow0_d  = din;
                        slot_d     = SLOT1;
                    end else begin
                        case (slot_q)
                            SLOT1: begin
                                shadow1_d = din;
                                slot_d    = SLOT2;
                            end
                            SLOT2: begin
                                shadow2_d = din;
                                slot_d    = SLOT3;
                            end
                            SLOT3: begin
                                out0_d        = shadow0_q;
                                out1_d        = shadow1_q;
                                out2_d        = shadow2_q;
                                out3_d        = din;
                                frame_valid_d = 1'b1;
                                slot_d        = SLOT0;
                            end
                            default: begin
                                sync_err_d = 1'b1;
                                state_d    = HUNT;
                                slot_d     = SLOT0;
                            end
                        endcase
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= HUNT;
            slot_q        <= SLOT0;
            shadow0_q     <= '0;
            shadow1_q     <= '0;
            shadow2_q     <= '0;
            out0_q        <= '0;
            out1_q        <= '0;
            out2_q        <= '0;
            out3_q        <= '0;
            frame_valid_q <= 1'b0;
            sync_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            slot_q        <= slot_d;
            shadow0_q     <= shadow0_d;
            shadow1_q     <= shadow1_d;
            shadow2_q     <= shadow2_d;
            out0_q        <= out0_d;
            out1_q        <= out1_d;
            out2_q        <= out2_d;
            out3_q        <= out3_d;
            frame_valid_q <= frame_valid_d;
            sync_err_q    <= sync_err_d;
        end
    end

    assign out0        = out0_q;
    assign out1        = out1_q;
    assign out2        = out2_q;
    assign out3        = out3_q;
    assign sel         = slot_q;
    assign frame_valid = frame_valid_q;
    assign locked      = (state_q == LOCKED);
    assign sync_err    = sync_err_q;

endmodule
